m68k_bus_decoder: RTL and testbench
===================================

Name: m68k_bus_decoder

Overview:
- Parametrised, registered successor to the combinational per-PCB 68k chip-select logic.
- Decodes a run-time region table of NUM_REGIONS entries: base, last, direction qualifier and per-region wait states.
- Produces one-hot chip selects, generates DTACK after programmable wait states, and raises BERR on unmapped accesses after a timeout.
- Sits between the fx68k bus pins and the per-PCB memory/IO muxes. The top level drives the region table from constants selected by pcb.

Parameters:
- NUM_REGIONS, 16, number of decode regions (1..32).
- ADDR_W, 24, compared address width.
- WAIT_W, 3, width of per-region wait-state count.
- TIMEOUT_CYC, 64, cycles without a hit before BERR is asserted (2..255).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- cfg_base  in  NUM_REGIONS*ADDR_W  region i inclusive start, slice [i*ADDR_W +: ADDR_W]
- cfg_last  in  NUM_REGIONS*ADDR_W  region i inclusive end
- cfg_wait  in  NUM_REGIONS*WAIT_W  region i wait states
- cfg_dir  in  NUM_REGIONS*2  region i qualifier: 00 any, 01 read-only, 10 write-only, 11 disabled
- m68k_a  in  ADDR_W  CPU address
- m68k_as_n  in  1  address strobe, active low, synchronous to clk
- m68k_rw  in  1  1 = read
- cs  out  NUM_REGIONS  registered one-hot chip selects
- hit_idx  out  $clog2(NUM_REGIONS)  index of selected region
- dtack_n  out  1  data acknowledge, active low
- berr_n  out  1  bus error, active low
- busy  out  1  state != IDLE

Behaviour:
- Reset (async): state IDLE; cs=0, hit_idx=0, dtack_n=1, berr_n=1, busy=0; counters 0.
- Region i hits when all of the following hold:
  - base_i <= addr <= last_i (unsigned);
  - dir_i != 11;
  - dir_i==01 requires rw=1; dir_i==10 requires rw=0.
- If several regions hit, the lowest index wins.
- FSM states: IDLE, DECODE, WAIT, ACK, TIMEOUT, BERR.
- IDLE: at edge T sampling as_n=0, latch addr and rw and go to DECODE. The config inputs are sampled in DECODE; the top level holds them stable during a cycle.
- DECODE, edge T+1:
  - Hit: cs[idx]=1, hit_idx=idx, wait counter loaded with wait_idx. Go to ACK with dtack_n=0 if wait_idx=0, else go to WAIT.
  - No hit: load the timeout counter with TIMEOUT_CYC-1 and go to TIMEOUT.
- WAIT: decrement each cycle. At the edge where the counter reaches 0 from 1, set dtack_n=0 and go to ACK. DTACK therefore falls at edge T+1+wait_idx.
- ACK: hold cs and dtack_n until as_n is sampled 1. At that edge set cs=0 and dtack_n=1 and go to IDLE.
- TIMEOUT: decrement each cycle. On 0, set berr_n=0 and go to BERR. BERR falls at edge T+1+TIMEOUT_CYC.
- BERR: hold berr_n=0 until as_n is sampled 1, then set berr_n=1 and go to IDLE.
- Abort: as_n sampled 1 in DECODE, WAIT or TIMEOUT. All outputs deassert at that edge and the FSM goes to IDLE; no DTACK or BERR is produced.
- Back-to-back cycles: a new as_n=0 is only accepted from IDLE. The minimum gap is one IDLE cycle after strobe release.
- Address is latched once per cycle; m68k_a changes during a held strobe are ignored.
- Reset mid-cycle: immediate return to reset values. dtack_n and berr_n are never both low.
- Boundaries:
  - base==last gives a single-word region.
  - base>last means the region never hits.
  - addr = 2^ADDR_W-1 is compared without wrap.

Optional Feature:
- Macro: BUS_DECODER_OVERLAP_CHECK_EN.
- Enabled:
  - adds output overlap_err (1 bit, sticky, cleared only by reset);
  - overlap_err sets at the DECODE edge when more than one region hits;
  - adds output overlap_mask (NUM_REGIONS), which captures the hit vector of the first overlapping access.
- Disabled: neither port exists and priority resolution is unchanged.

Decomposition:
- Shared package bus_decoder_pkg holds:
  - the direction encodings DIR_ANY, DIR_RD, DIR_WR, DIR_OFF;
  - the state enum;
  - the per-PCB region table constants (NEXTSPACE and PADDLEMANIA maps) that the top level muxes onto cfg_*.
- Sub-module bus_region_match: purely combinational, NUM_REGIONS-wide compare plus priority encoder. It outputs the hit vector, the winning index and a valid flag. The FSM stays in m68k_bus_decoder.

Test Plan:
- Reset held then released → cs=0, dtack_n=1, berr_n=1, busy=0.
- Region 0 = 0x000000..0x03FFFF, wait 0; read 0x01234A → cs[0]=1 and dtack_n=0 at T+1; both clear on the edge as_n rises.
- Region 1 = 0x070000..0x073FFF, wait 3; write 0x070010 → cs[1] at T+1, dtack_n=0 at T+4; as_n released at T+2 instead → no DTACK, cs=0 at T+3.
- Region 2 read-only at 0x0E0000..0x0E0001; write to 0x0E0000 with no other hit, TIMEOUT_CYC=8 → cs=0, berr_n=0 at T+9 and held until as_n=1.
- Regions 3 and 5 both cover 0x0F0008; read → cs=6'b001000 in bits [5:0], hit_idx=3; with macro enabled, overlap_err=1 and overlap_mask bits 3 and 5 set.
- Region 4 = 0xFFFFFE..0xFFFFFF; access 0xFFFFFF → hit. Reset asserted during a WAIT at the second wait cycle → outputs cleared immediately and next cycle decodes normally.

Source files
------------

// File: rtl/bus_decoder_pkg.sv
// Shared types for the 68k bus decoder: direction codes, FSM states and the
// per-PCB region tables a board wrapper muxes onto the decoder's cfg_* inputs.
package bus_decoder_pkg;

  typedef enum logic [1:0] {
    DIR_ANY = 2'b00,
    DIR_RD  = 2'b01,
    DIR_WR  = 2'b10,
    DIR_OFF = 2'b11
  } dir_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_WAIT,
    ST_ACK,
    ST_TIMEOUT,
    ST_BERR
  } state_e;

  typedef enum logic {
    PCB_NEXTSPACE,
    PCB_PADDLEMANIA
  } pcb_e;

  localparam int PCB_REGIONS = 16;
  localparam int PCB_ADDR_W  = 24;
  localparam int PCB_WAIT_W  = 3;

  typedef struct packed {
    logic [PCB_ADDR_W-1:0] base;
    logic [PCB_ADDR_W-1:0] last;
    dir_e                  dir;
    logic [PCB_WAIT_W-1:0] wait_st;
  } region_t;

  typedef struct packed {
    logic [PCB_REGIONS*PCB_ADDR_W-1:0] base;
    logic [PCB_REGIONS*PCB_ADDR_W-1:0] last;
    logic [PCB_REGIONS*PCB_WAIT_W-1:0] wait_st;
    logic [PCB_REGIONS*2-1:0]          dir;
  } region_cfg_t;

  // Unused slots use base > last so they can never hit even if re-enabled.
  localparam region_t REGION_NONE = '{24'hFFFFFF, 24'h000000, DIR_OFF, 3'd0};

  localparam region_t NEXTSPACE_MAP [PCB_REGIONS] = '{
    '{24'h000000, 24'h03FFFF, DIR_RD,  3'd0},
    '{24'h070000, 24'h073FFF, DIR_ANY, 3'd0},
    '{24'h0A0000, 24'h0A3FFF, DIR_ANY, 3'd1},
    '{24'h0C0000, 24'h0C001F, DIR_RD,  3'd1},
    '{24'h0E0000, 24'h0E0001, DIR_WR,  3'd1},
    '{24'h0F0000, 24'h0F0001, DIR_WR,  3'd0},
    '{24'h0F8000, 24'h0F8001, DIR_WR,  3'd0},
    REGION_NONE, REGION_NONE, REGION_NONE, REGION_NONE, REGION_NONE,
    REGION_NONE, REGION_NONE, REGION_NONE, REGION_NONE
  };

  localparam region_t PADDLEMANIA_MAP [PCB_REGIONS] = '{
    '{24'h000000, 24'h03FFFF, DIR_RD,  3'd0},
    '{24'h070000, 24'h073FFF, DIR_ANY, 3'd0},
    '{24'h080000, 24'h080001, DIR_RD,  3'd2},
    '{24'h080002, 24'h080003, DIR_RD,  3'd2},
    '{24'h090000, 24'h090001, DIR_WR,  3'd1},
    '{24'h0A0000, 24'h0A0FFF, DIR_ANY, 3'd1},
    '{24'h0C0000, 24'h0C0001, DIR_WR,  3'd0},
    '{24'h0D0000, 24'h0D0FFF, DIR_ANY, 3'd3},
    REGION_NONE, REGION_NONE, REGION_NONE, REGION_NONE,
    REGION_NONE, REGION_NONE, REGION_NONE, REGION_NONE
  };

  function automatic region_cfg_t region_cfg(input pcb_e pcb);
    region_cfg_t c;
    region_t     r;
    c = '0;
    for (int i = 0; i < PCB_REGIONS; i++) begin
      r = (pcb == PCB_PADDLEMANIA) ? PADDLEMANIA_MAP[i] : NEXTSPACE_MAP[i];
      c.base[i*PCB_ADDR_W +: PCB_ADDR_W]    = r.base;
      c.last[i*PCB_ADDR_W +: PCB_ADDR_W]    = r.last;
      c.wait_st[i*PCB_WAIT_W +: PCB_WAIT_W] = r.wait_st;
      c.dir[i*2 +: 2]                       = r.dir;
    end
    return c;
  endfunction

endpackage

// File: rtl/m68k_bus_decoder_if.sv
// 68k bus pins between the CPU core (master) and the decoder (slave).
interface m68k_bus_if #(
  parameter int ADDR_W = 24
);
  logic [ADDR_W-1:0] m68k_a;
  logic              m68k_as_n;
  logic              m68k_rw;
  logic              dtack_n;
  logic              berr_n;

  modport master (
    output m68k_a, m68k_as_n, m68k_rw,
    input  dtack_n, berr_n
  );

  modport slave (
    input  m68k_a, m68k_as_n, m68k_rw,
    output dtack_n, berr_n
  );
endinterface

// File: rtl/bus_region_match.sv
// Combinational region compare against the latched address plus a
// lowest-index-wins priority encoder.
module bus_region_match
  import bus_decoder_pkg::*;
#(
  parameter int NUM_REGIONS = 16,
  parameter int ADDR_W      = 24,
  parameter int IDX_W       = 4
) (
  input  logic [ADDR_W-1:0]             addr,
  input  logic                          rw,
  input  logic [NUM_REGIONS*ADDR_W-1:0] cfg_base,
  input  logic [NUM_REGIONS*ADDR_W-1:0] cfg_last,
  input  logic [NUM_REGIONS*2-1:0]      cfg_dir,
  output logic [NUM_REGIONS-1:0]        hit_vec,
  output logic [IDX_W-1:0]              hit_idx,
  output logic                          hit_vld
);

  always_comb begin
    logic [1:0] dir;
    hit_vec = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      dir = cfg_dir[i*2 +: 2];
      hit_vec[i] = (cfg_base[i*ADDR_W +: ADDR_W] <= addr) &&
                   (addr <= cfg_last[i*ADDR_W +: ADDR_W]) &&
                   (dir != DIR_OFF) &&
                   !((dir == DIR_RD) && !rw) &&
                   !((dir == DIR_WR) && rw);
    end
  end

  // Scan downward so the last assignment is the lowest hitting index.
  always_comb begin
    hit_idx = '0;
    hit_vld = 1'b0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        hit_idx = IDX_W'(i);
        hit_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/m68k_bus_decoder.sv
// Registered 68k chip-select decoder with programmable DTACK wait states and BERR timeout.
// Optional BUS_DECODER_OVERLAP_CHECK_EN adds sticky overlap_err / overlap_mask outputs.
module m68k_bus_decoder
  import bus_decoder_pkg::*;
#(
  parameter int NUM_REGIONS = 16,
  parameter int ADDR_W      = 24,
  parameter int WAIT_W      = 3,
  parameter int TIMEOUT_CYC = 64,
  localparam int IDX_W      = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REGIONS*ADDR_W-1:0] cfg_base,
  input  logic [NUM_REGIONS*ADDR_W-1:0] cfg_last,
  input  logic [NUM_REGIONS*WAIT_W-1:0] cfg_wait,
  input  logic [NUM_REGIONS*2-1:0]      cfg_dir,
  m68k_bus_if.slave                     bus,
  output logic [NUM_REGIONS-1:0]        cs,
  output logic [IDX_W-1:0]              hit_idx,
  output logic                          busy
`ifdef BUS_DECODER_OVERLAP_CHECK_EN
  ,
  output logic                          overlap_err,
  output logic [NUM_REGIONS-1:0]        overlap_mask
`endif
);

  // state | meaning: IDLE wait strobe, DECODE compare, WAIT count wait states,
  // ACK dtack held, TIMEOUT unmapped countdown, BERR berr held
  localparam int CNT_W = (WAIT_W > 8) ? WAIT_W : 8;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  rw_q, rw_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_REGIONS-1:0] cs_q, cs_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  dtack_n_q, dtack_n_d;
  logic                  berr_n_q, berr_n_d;

  logic [NUM_REGIONS-1:0] hit_vec;
  logic [IDX_W-1:0]       win_idx;
  logic                   win_vld;
  logic [WAIT_W-1:0]      win_wait;

  bus_region_match #(
    .NUM_REGIONS (NUM_REGIONS),
    .ADDR_W      (ADDR_W),
    .IDX_W       (IDX_W)
  ) u_match (
    .addr     (addr_q),
    .rw       (rw_q),
    .cfg_base (cfg_base),
    .cfg_last (cfg_last),
    .cfg_dir  (cfg_dir),
    .hit_vec  (hit_vec),
    .hit_idx  (win_idx),
    .hit_vld  (win_vld)
  );

  assign win_wait = cfg_wait[int'(win_idx)*WAIT_W +: WAIT_W];

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    cnt_d     = cnt_q;
    cs_d      = cs_q;
    idx_d     = idx_q;
    dtack_n_d = dtack_n_q;
    berr_n_d  = berr_n_q;
    case (state_q)
      ST_IDLE: begin
        if (!bus.m68k_as_n) begin
          addr_d  = bus.m68k_a;
          rw_d    = bus.m68k_rw;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (bus.m68k_as_n) begin
          state_d = ST_IDLE;
        end else if (win_vld) begin
          // Isolating the lowest set hit bit gives the same one-hot as win_idx.
          cs_d  = hit_vec & ~(hit_vec - NUM_REGIONS'(1));
          idx_d = win_idx;
          cnt_d = CNT_W'(win_wait);
          if (win_wait == '0) begin
            dtack_n_d = 1'b0;
            state_d   = ST_ACK;
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          cnt_d   = CNT_W'(TIMEOUT_CYC - 1);
          state_d = ST_TIMEOUT;
        end
      end
      ST_WAIT: begin
        if (bus.m68k_as_n) begin
          cs_d    = '0;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            dtack_n_d = 1'b0;
            state_d   = ST_ACK;
          end
        end
      end
      ST_ACK: begin
        if (bus.m68k_as_n) begin
          cs_d      = '0;
          idx_d     = '0;
          dtack_n_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_TIMEOUT: begin
        if (bus.m68k_as_n) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          berr_n_d = 1'b0;
          state_d  = ST_BERR;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_BERR: begin
        if (bus.m68k_as_n) begin
          berr_n_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        cs_d      = '0;
        idx_d     = '0;
        cnt_d     = '0;
        dtack_n_d = 1'b1;
        berr_n_d  = 1'b1;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      cnt_q     <= '0;
      cs_q      <= '0;
      idx_q     <= '0;
      dtack_n_q <= 1'b1;
      berr_n_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      cnt_q     <= cnt_d;
      cs_q      <= cs_d;
      idx_q     <= idx_d;
      dtack_n_q <= dtack_n_d;
      berr_n_q  <= berr_n_d;
    end
  end

`ifdef BUS_DECODER_OVERLAP_CHECK_EN
  logic                   ovl_err_q, ovl_err_d;
  logic [NUM_REGIONS-1:0] ovl_mask_q, ovl_mask_d;
  logic                   multi_hit;

  assign multi_hit = (hit_vec & (hit_vec - NUM_REGIONS'(1))) != '0;

  // Only the first overlapping access is captured; later ones leave the mask alone.
  always_comb begin
    ovl_err_d  = ovl_err_q;
    ovl_mask_d = ovl_mask_q;
    if ((state_q == ST_DECODE) && multi_hit && !ovl_err_q) begin
      ovl_err_d  = 1'b1;
      ovl_mask_d = hit_vec;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovl_err_q  <= 1'b0;
      ovl_mask_q <= '0;
    end else begin
      ovl_err_q  <= ovl_err_d;
      ovl_mask_q <= ovl_mask_d;
    end
  end

  assign overlap_err  = ovl_err_q;
  assign overlap_mask = ovl_mask_q;
`endif

  assign cs          = cs_q;
  assign hit_idx     = idx_q;
  assign bus.dtack_n = dtack_n_q;
  assign bus.berr_n  = berr_n_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_m68k_bus_decoder.sv
// Scoreboard bench for m68k_bus_decoder: a bench-side region model predicts
// the response of each access, which is compared when DTACK or BERR falls.
module tb_m68k_bus_decoder;
  import bus_decoder_pkg::*;

  localparam int NR = 8;
  localparam int AW = 24;
  localparam int WW = 3;
  localparam int TO = 8;
  localparam int IW = 3;
  localparam int LIMIT = 40;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NR*AW-1:0] cfg_base, cfg_last;
  logic [NR*WW-1:0] cfg_wait;
  logic [NR*2-1:0]  cfg_dir;
  logic [NR-1:0]    cs;
  logic [IW-1:0]    hit_idx;
  logic             busy;
`ifdef BUS_DECODER_OVERLAP_CHECK_EN
  logic             overlap_err;
  logic [NR-1:0]    overlap_mask;
`endif

  m68k_bus_if #(.ADDR_W(AW)) bus ();

  m68k_bus_decoder #(
    .NUM_REGIONS (NR),
    .ADDR_W      (AW),
    .WAIT_W      (WW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_base (cfg_base),
    .cfg_last (cfg_last),
    .cfg_wait (cfg_wait),
    .cfg_dir  (cfg_dir),
    .bus      (bus),
    .cs       (cs),
    .hit_idx  (hit_idx),
    .busy     (busy)
`ifdef BUS_DECODER_OVERLAP_CHECK_EN
    ,
    .overlap_err  (overlap_err),
    .overlap_mask (overlap_mask)
`endif
  );

  logic [AW-1:0] t_base [NR];
  logic [AW-1:0] t_last [NR];
  logic [WW-1:0] t_wait [NR];
  dir_e          t_dir  [NR];

  typedef struct {
    logic [NR-1:0] cs;
    logic [IW-1:0] idx;
    logic          dtack_n;
    logic          berr_n;
    int            lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic exp_t model(input logic [AW-1:0] a, input logic rw);
    exp_t e;
    logic found;
    found     = 1'b0;
    e.cs      = '0;
    e.idx     = '0;
    e.dtack_n = 1'b1;
    e.berr_n  = 1'b0;
    e.lat     = 1 + TO;
    for (int i = 0; i < NR; i++) begin
      if (!found && a >= t_base[i] && a <= t_last[i] && t_dir[i] != DIR_OFF &&
          (t_dir[i] != DIR_RD || rw) && (t_dir[i] != DIR_WR || !rw)) begin
        found     = 1'b1;
        e.cs      = NR'(1) << i;
        e.idx     = IW'(i);
        e.dtack_n = 1'b0;
        e.berr_n  = 1'b1;
        e.lat     = 1 + int'(t_wait[i]);
      end
    end
    return e;
  endfunction

  // Called at a negedge; the following posedge is edge T.
  task automatic drive(input logic [AW-1:0] a, input logic rw);
    sb.push_back(model(a, rw));
    bus.m68k_a    = a;
    bus.m68k_rw   = rw;
    bus.m68k_as_n = 1'b0;
  endtask

  // cyc-1 is the edge offset from T at which a response became visible.
  // The address is scrambled after T so a re-decode would be visible.
  task automatic wait_resp(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) bus.m68k_a = ~bus.m68k_a;
    end while (bus.dtack_n && bus.berr_n && cyc < LIMIT);
  endtask

  task automatic test_reset;
    bus.m68k_as_n = 1'b1;
    bus.m68k_rw   = 1'b1;
    bus.m68k_a    = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({cs, hit_idx, bus.dtack_n, bus.berr_n, busy} !== {8'h00, 3'd0, 1'b1, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL reset_hold: cs=%h idx=%0d dtack_n=%b berr_n=%b busy=%b, want 00/0/1/1/0",
               cs, hit_idx, bus.dtack_n, bus.berr_n, busy);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({cs, hit_idx, bus.dtack_n, bus.berr_n, busy} !== {8'h00, 3'd0, 1'b1, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL reset_release: cs=%h idx=%0d dtack_n=%b berr_n=%b busy=%b, want 00/0/1/1/0",
               cs, hit_idx, bus.dtack_n, bus.berr_n, busy);
    end
  endtask

  task automatic test_wait0;
    exp_t e;
    int   cyc;
    drive(24'h01234A, 1'b1);
    wait_resp(cyc);
    e = sb.pop_front();
    n_vec++;
    if (cs !== e.cs || hit_idx !== e.idx || bus.dtack_n !== e.dtack_n || bus.berr_n !== e.berr_n || cyc - 1 !== e.lat) begin
      n_err++;
      $display("FAIL wait0_resp: cs=%h idx=%0d dtack_n=%b berr_n=%b at T+%0d, want cs=%h idx=%0d dtack_n=%b berr_n=%b at T+%0d",
               cs, hit_idx, bus.dtack_n, bus.berr_n, cyc - 1, e.cs, e.idx, e.dtack_n, e.berr_n, e.lat);
    end
    @(negedge clk);
    n_vec++;
    if (cs !== 8'h01 || bus.dtack_n !== 1'b0) begin
      n_err++;
      $display("FAIL wait0_hold: cs=%h dtack_n=%b, want 01/0", cs, bus.dtack_n);
    end
    bus.m68k_as_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (cs !== 8'h00 || bus.dtack_n !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL wait0_release: cs=%h dtack_n=%b busy=%b, want 00/1/0", cs, bus.dtack_n, busy);
    end
  endtask

  task automatic test_wait3;
    exp_t e;
    int   cyc;
    drive(24'h070010, 1'b0);
    wait_resp(cyc);
    e = sb.pop_front();
    n_vec++;
    if (cs !== e.cs || hit_idx !== e.idx || bus.dtack_n !== e.dtack_n || bus.berr_n !== e.berr_n || cyc - 1 !== e.lat) begin
      n_err++;
      $display("FAIL wait3_resp: cs=%h idx=%0d dtack_n=%b berr_n=%b at T+%0d, want cs=%h idx=%0d dtack_n=%b berr_n=%b at T+%0d",
               cs, hit_idx, bus.dtack_n, bus.berr_n, cyc - 1, e.cs, e.idx, e.dtack_n, e.berr_n, e.lat);
    end
    bus.m68k_as_n = 1'b1;
    repeat (2) @(negedge clk);
    // Aborted variant: strobe released after edge T+2.
    bus.m68k_a    = 24'h070010;
    bus.m68k_rw   = 1'b0;
    bus.m68k_as_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (cs !== 8'h02 || hit_idx !== 3'd1 || bus.dtack_n !== 1'b1) begin
      n_err++;
      $display("FAIL abort_cs: cs=%h idx=%0d dtack_n=%b at T+1, want 02/1/1", cs, hit_idx, bus.dtack_n);
    end
    @(negedge clk);
    bus.m68k_as_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (cs !== 8'h00 || hit_idx !== 3'd0 || bus.dtack_n !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL abort_clear: cs=%h idx=%0d dtack_n=%b busy=%b at T+3, want 00/0/1/0",
               cs, hit_idx, bus.dtack_n, busy);
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (bus.dtack_n !== 1'b1 || bus.berr_n !== 1'b1) begin
      n_err++;
      $display("FAIL abort_quiet: dtack_n=%b berr_n=%b, want 1/1", bus.dtack_n, bus.berr_n);
    end
  endtask

  task automatic test_timeout;
    exp_t e;
    int   cyc;
    drive(24'h0E0000, 1'b0);
    wait_resp(cyc);
    e = sb.pop_front();
    n_vec++;
    if (cs !== e.cs || hit_idx !== e.idx || bus.dtack_n !== e.dtack_n || bus.berr_n !== e.berr_n || cyc - 1 !== e.lat) begin
      n_err++;
      $display("FAIL timeout_resp: cs=%h idx=%0d dtack_n=%b berr_n=%b at T+%0d, want cs=%h idx=%0d dtack_n=%b berr_n=%b at T+%0d",
               cs, hit_idx, bus.dtack_n, bus.berr_n, cyc - 1, e.cs, e.idx, e.dtack_n, e.berr_n, e.lat);
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (bus.berr_n !== 1'b0 || bus.dtack_n !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL berr_hold: berr_n=%b dtack_n=%b busy=%b, want 0/1/1", bus.berr_n, bus.dtack_n, busy);
    end
    bus.m68k_as_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (bus.berr_n !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL berr_release: berr_n=%b busy=%b, want 1/0", bus.berr_n, busy);
    end
  endtask

  task automatic test_overlap;
    exp_t e;
    int   cyc;
    drive(24'h0F0008, 1'b1);
    wait_resp(cyc);
    e = sb.pop_front();
    n_vec++;
    if (cs !== e.cs || hit_idx !== e.idx || bus.dtack_n !== e.dtack_n || bus.berr_n !== e.berr_n || cyc - 1 !== e.lat) begin
      n_err++;
      $display("FAIL overlap_resp: cs=%h idx=%0d dtack_n=%b berr_n=%b at T+%0d, want cs=%h idx=%0d dtack_n=%b berr_n=%b at T+%0d",
               cs, hit_idx, bus.dtack_n, bus.berr_n, cyc - 1, e.cs, e.idx, e.dtack_n, e.berr_n, e.lat);
    end
    n_vec++;
    if (cs[5:0] !== 6'b001000 || hit_idx !== 3'd3) begin
      n_err++;
      $display("FAIL overlap_prio: cs=%b idx=%0d, want 001000/3", cs[5:0], hit_idx);
    end
`ifdef BUS_DECODER_OVERLAP_CHECK_EN
    n_vec++;
    if (overlap_err !== 1'b1 || overlap_mask !== 8'b0010_1000) begin
      n_err++;
      $display("FAIL overlap_flag: err=%b mask=%b, want 1/00101000", overlap_err, overlap_mask);
    end
`endif
    bus.m68k_as_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_top_addr;
    exp_t e;
    int   cyc;
    drive(24'hFFFFFF, 1'b1);
    wait_resp(cyc);
    e = sb.pop_front();
    n_vec++;
    if (cs !== e.cs || hit_idx !== e.idx || bus.dtack_n !== e.dtack_n || bus.berr_n !== e.berr_n || cyc - 1 !== e.lat) begin
      n_err++;
      $display("FAIL top_addr_resp: cs=%h idx=%0d dtack_n=%b berr_n=%b at T+%0d, want cs=%h idx=%0d dtack_n=%b berr_n=%b at T+%0d",
               cs, hit_idx, bus.dtack_n, bus.berr_n, cyc - 1, e.cs, e.idx, e.dtack_n, e.berr_n, e.lat);
    end
    bus.m68k_as_n = 1'b1;
    @(negedge clk);
    // Reset in the second wait cycle of a 2-wait access.
    bus.m68k_a    = 24'hFFFFFF;
    bus.m68k_rw   = 1'b1;
    bus.m68k_as_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (cs !== 8'h10 || bus.dtack_n !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset_wait: cs=%h dtack_n=%b, want 10/1", cs, bus.dtack_n);
    end
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if ({cs, hit_idx, bus.dtack_n, bus.berr_n, busy} !== {8'h00, 3'd0, 1'b1, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL mid_reset: cs=%h idx=%0d dtack_n=%b berr_n=%b busy=%b, want 00/0/1/1/0",
               cs, hit_idx, bus.dtack_n, bus.berr_n, busy);
    end
    @(negedge clk);
    reset         = 1'b0;
    bus.m68k_as_n = 1'b1;
    @(negedge clk);
    drive(24'h000010, 1'b1);
    wait_resp(cyc);
    e = sb.pop_front();
    n_vec++;
    if (cs !== e.cs || hit_idx !== e.idx || bus.dtack_n !== e.dtack_n || bus.berr_n !== e.berr_n || cyc - 1 !== e.lat) begin
      n_err++;
      $display("FAIL post_reset_resp: cs=%h idx=%0d dtack_n=%b berr_n=%b at T+%0d, want cs=%h idx=%0d dtack_n=%b berr_n=%b at T+%0d",
               cs, hit_idx, bus.dtack_n, bus.berr_n, cyc - 1, e.cs, e.idx, e.dtack_n, e.berr_n, e.lat);
    end
    bus.m68k_as_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_boundaries;
    logic [AW-1:0] addrs [6] = '{24'h03FFFF, 24'h040000, 24'h100000, 24'h100000, 24'h100001, 24'h200010};
    logic          rws   [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_t e;
    int   cyc;
    for (int k = 0; k < 6; k++) begin
      drive(addrs[k], rws[k]);
      wait_resp(cyc);
      e = sb.pop_front();
      n_vec++;
      if (cs !== e.cs || hit_idx !== e.idx || bus.dtack_n !== e.dtack_n || bus.berr_n !== e.berr_n || cyc - 1 !== e.lat) begin
        n_err++;
        $display("FAIL boundary_%0d a=%h: cs=%h idx=%0d dtack_n=%b berr_n=%b at T+%0d, want cs=%h idx=%0d dtack_n=%b berr_n=%b at T+%0d",
                 k, addrs[k], cs, hit_idx, bus.dtack_n, bus.berr_n, cyc - 1, e.cs, e.idx, e.dtack_n, e.berr_n, e.lat);
      end
      bus.m68k_as_n = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int   cyc;
    drive(24'h000100, 1'b1);
    wait_resp(cyc);
    e = sb.pop_front();
    n_vec++;
    if (cs !== e.cs || hit_idx !== e.idx || bus.dtack_n !== e.dtack_n || bus.berr_n !== e.berr_n || cyc - 1 !== e.lat) begin
      n_err++;
      $display("FAIL b2b_first: cs=%h idx=%0d dtack_n=%b berr_n=%b at T+%0d, want cs=%h idx=%0d dtack_n=%b berr_n=%b at T+%0d",
               cs, hit_idx, bus.dtack_n, bus.berr_n, cyc - 1, e.cs, e.idx, e.dtack_n, e.berr_n, e.lat);
    end
    bus.m68k_as_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (cs !== 8'h00 || bus.dtack_n !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_gap: cs=%h dtack_n=%b busy=%b, want 00/1/0", cs, bus.dtack_n, busy);
    end
    drive(24'h0F0000, 1'b1);
    wait_resp(cyc);
    e = sb.pop_front();
    n_vec++;
    if (cs !== e.cs || hit_idx !== e.idx || bus.dtack_n !== e.dtack_n || bus.berr_n !== e.berr_n || cyc - 1 !== e.lat) begin
      n_err++;
      $display("FAIL b2b_second: cs=%h idx=%0d dtack_n=%b berr_n=%b at T+%0d, want cs=%h idx=%0d dtack_n=%b berr_n=%b at T+%0d",
               cs, hit_idx, bus.dtack_n, bus.berr_n, cyc - 1, e.cs, e.idx, e.dtack_n, e.berr_n, e.lat);
    end
    bus.m68k_as_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    t_base = '{24'h000000, 24'h070000, 24'h0E0000, 24'h0F0000, 24'hFFFFFE, 24'h0F0008, 24'h100000, 24'h200010};
    t_last = '{24'h03FFFF, 24'h073FFF, 24'h0E0001, 24'h0F000F, 24'hFFFFFF, 24'h0F00FF, 24'h100000, 24'h20000F};
    t_wait = '{3'd0, 3'd3, 3'd0, 3'd1, 3'd2, 3'd0, 3'd0, 3'd0};
    t_dir  = '{DIR_ANY, DIR_ANY, DIR_RD, DIR_ANY, DIR_ANY, DIR_ANY, DIR_WR, DIR_ANY};
    for (int i = 0; i < NR; i++) begin
      cfg_base[i*AW +: AW] = t_base[i];
      cfg_last[i*AW +: AW] = t_last[i];
      cfg_wait[i*WW +: WW] = t_wait[i];
      cfg_dir[i*2 +: 2]    = t_dir[i];
    end
    test_reset();
    test_wait0();
    test_wait3();
    test_timeout();
    test_overlap();
    test_top_addr();
    test_boundaries();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

endmodule
